// File: rtl/checker_pkg.sv
// Shared widths, FSM encoding and helpers for the register-file write checker.
package checker_pkg;

    localparam int IDX_W   = 6;
    localparam int REG_W   = 5;
    localparam int DATA_W  = 32;
    localparam int ERR_W   = 8;
    localparam int ENTRY_W = REG_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] value);
        return (value == '1) ? value : value + ERR_W'(1);
    endfunction

endpackage

// File: rtl/regwrite_checker_if.sv
// Table load port, snooped regfile write port and verdict outputs of the checker.
interface regwrite_checker_if;
    import checker_pkg::*;

    logic              load_en;
    logic [IDX_W-1:0]  load_idx;
    logic [REG_W-1:0]  load_reg;
    logic [DATA_W-1:0] load_data;
    logic              start;
    logic              ctrl_writeEnable;
    logic [REG_W-1:0]  ctrl_writeReg;
    logic [DATA_W-1:0] data_writeReg;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [ERR_W-1:0]  error_count;
    logic [IDX_W-1:0]  check_idx;
    logic [IDX_W-1:0]  fail_idx;
    logic [DATA_W-1:0] fail_data;

    modport master (
        output load_en, load_idx, load_reg, load_data, start,
               ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  busy, done, pass, timeout, error_count, check_idx, fail_idx, fail_data
    );

    modport slave (
        input  load_en, load_idx, load_reg, load_data, start,
               ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output busy, done, pass, timeout, error_count, check_idx, fail_idx, fail_data
    );

endinterface

// File: rtl/expect_table.sv
// Expected-write table: synchronous write, asynchronous read, contents survive reset.
module expect_table
    import checker_pkg::*;
#(
    parameter int NUM_EXPECT = 16
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [REG_W-1:0]  wr_reg,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [REG_W-1:0]  rd_reg,
    output logic [DATA_W-1:0] rd_data
);

    localparam int AW = (NUM_EXPECT > 1) ? $clog2(NUM_EXPECT) : 1;
    localparam logic [IDX_W:0] DEPTH = (IDX_W + 1)'(NUM_EXPECT);

    logic [ENTRY_W-1:0] entries [NUM_EXPECT];
    logic               wr_hit;
    logic               rd_hit;
    logic [ENTRY_W-1:0] rd_entry;

    // Range checks use one extra bit so NUM_EXPECT = 64 does not wrap to zero.
    assign wr_hit = wr_en && ({1'b0, wr_idx} < DEPTH);
    assign rd_hit = {1'b0, rd_idx} < DEPTH;

    always_ff @(posedge clock) begin
        if (wr_hit) begin
            entries[wr_idx[AW-1:0]] <= {wr_reg, wr_data};
        end
    end

    assign rd_entry = rd_hit ? entries[rd_idx[AW-1:0]] : '0;
    assign rd_reg   = rd_entry[ENTRY_W-1:DATA_W];
    assign rd_data  = rd_entry[DATA_W-1:0];

endmodule

// File: rtl/regwrite_checker.sv
// Compares each committed register-file write, in order, against the preloaded
// expected-write table and reports a pass/fail verdict with first-mismatch details.
module regwrite_checker
    import checker_pkg::*;
#(
    parameter int NUM_EXPECT = 16,
    parameter int TIMEOUT    = 255
) (
    input logic               clock,
    input logic               reset,
    regwrite_checker_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W:0] LAST_IDX = (IDX_W + 1)'(NUM_EXPECT);

    state_t            state;
    logic              busy_r;
    logic              done_r;
    logic              pass_r;
    logic              timeout_r;
    logic [ERR_W-1:0]  err_r;
    logic [IDX_W-1:0]  check_idx_r;
    logic [IDX_W-1:0]  fail_idx_r;
    logic [DATA_W-1:0] fail_data_r;
    logic              fail_seen;
    logic [CNT_W-1:0]  idle_cnt;

    logic [REG_W-1:0]  exp_reg;
    logic [DATA_W-1:0] exp_data;
    logic              checked_write;
    logic              mismatch;
    logic [ERR_W-1:0]  err_next;
    logic [IDX_W:0]    next_idx;
    logic [CNT_W-1:0]  idle_inc;

    expect_table #(.NUM_EXPECT(NUM_EXPECT)) u_table (
        .clock   (clock),
        .wr_en   (bus.load_en && (state == IDLE)),
        .wr_idx  (bus.load_idx),
        .wr_reg  (bus.load_reg),
        .wr_data (bus.load_data),
        .rd_idx  (check_idx_r),
        .rd_reg  (exp_reg),
        .rd_data (exp_data)
    );

    // Writes to $r0 are discarded by the regfile, so they never count.
    assign checked_write = bus.ctrl_writeEnable && (bus.ctrl_writeReg != '0);
    assign mismatch      = (bus.ctrl_writeReg != exp_reg) || (bus.data_writeReg != exp_data);
    assign err_next      = mismatch ? sat_inc(err_r) : err_r;
    assign next_idx      = {1'b0, check_idx_r} + (IDX_W + 1)'(1);
    assign idle_inc      = idle_cnt + CNT_W'(1);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            timeout_r   <= 1'b0;
            err_r       <= '0;
            check_idx_r <= '0;
            fail_idx_r  <= '0;
            fail_data_r <= '0;
            fail_seen   <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state       <= RUN;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                        pass_r      <= 1'b0;
                        timeout_r   <= 1'b0;
                        err_r       <= '0;
                        check_idx_r <= '0;
                        fail_idx_r  <= '0;
                        fail_data_r <= '0;
                        fail_seen   <= 1'b0;
                        idle_cnt    <= '0;
                    end else if ((state == DONE) && checked_write) begin
                        err_r  <= sat_inc(err_r);
                        pass_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (checked_write) begin
                        err_r       <= err_next;
                        check_idx_r <= next_idx[IDX_W-1:0];
                        idle_cnt    <= '0;
                        if (mismatch && !fail_seen) begin
                            fail_seen   <= 1'b1;
                            fail_idx_r  <= check_idx_r;
                            fail_data_r <= bus.data_writeReg;
                        end
                        if (next_idx == LAST_IDX) begin
                            state  <= DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            pass_r <= (err_next == '0);
                        end
                    end else begin
                        idle_cnt <= idle_inc;
                        if (idle_inc == CNT_W'(TIMEOUT)) begin
                            state     <= DONE;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                            pass_r    <= 1'b0;
                            timeout_r <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.pass        = pass_r;
    assign bus.timeout     = timeout_r;
    assign bus.error_count = err_r;
    assign bus.check_idx   = check_idx_r;
    assign bus.fail_idx    = fail_idx_r;
    assign bus.fail_data   = fail_data_r;

endmodule

// File: tb/tb_regwrite_checker.sv
// Directed bench for regwrite_checker with NUM_EXPECT=3 and TIMEOUT=8.
module tb_regwrite_checker;
    import checker_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    regwrite_checker_if bus();

    regwrite_checker #(.NUM_EXPECT(3), .TIMEOUT(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic en, input logic [4:0] rd, input logic [31:0] data);
        bus.ctrl_writeEnable = en;
        bus.ctrl_writeReg    = rd;
        bus.data_writeReg    = data;
        tick();
        bus.ctrl_writeEnable = 1'b0;
        bus.ctrl_writeReg    = '0;
        bus.data_writeReg    = '0;
    endtask

    task automatic load_entry(input logic [5:0] idx, input logic [4:0] rd, input logic [31:0] data);
        bus.load_en   = 1'b1;
        bus.load_idx  = idx;
        bus.load_reg  = rd;
        bus.load_data = data;
        tick();
        bus.load_en   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_busy"},      32'(bus.busy),        32'd0);
        check_output({tag, "_done"},      32'(bus.done),        32'd0);
        check_output({tag, "_pass"},      32'(bus.pass),        32'd0);
        check_output({tag, "_timeout"},   32'(bus.timeout),     32'd0);
        check_output({tag, "_err"},       32'(bus.error_count), 32'd0);
        check_output({tag, "_check_idx"}, 32'(bus.check_idx),   32'd0);
        check_output({tag, "_fail_idx"},  32'(bus.fail_idx),    32'd0);
        check_output({tag, "_fail_data"}, bus.fail_data,        32'd0);
    endtask

    initial begin
        bus.load_en = 1'b0;          bus.load_idx = '0;
        bus.load_reg = '0;           bus.load_data = '0;
        bus.start = 1'b0;            bus.ctrl_writeEnable = 1'b0;
        bus.ctrl_writeReg = '0;      bus.data_writeReg = '0;

        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b1;

        load_entry(6'd0, 5'd1, 32'h5);
        load_entry(6'd1, 5'd2, 32'hA);
        load_entry(6'd2, 5'd3, 32'hF);

        // All match, with a $r0 write interleaved
        pulse_start();
        check_output("run_busy", 32'(bus.busy), 32'd1);
        check_output("run_idx0", 32'(bus.check_idx), 32'd0);
        apply_stimulus(1'b1, 5'd1, 32'h5);
        check_output("match_idx1", 32'(bus.check_idx), 32'd1);
        apply_stimulus(1'b1, 5'd0, 32'hDEAD);
        check_output("r0_ignored", 32'(bus.check_idx), 32'd1);
        bus.ctrl_writeEnable = 1'b1; bus.ctrl_writeReg = 5'd2; bus.data_writeReg = 32'hA;
        tick();
        check_output("match_idx2", 32'(bus.check_idx), 32'd2);
        check_output("match_not_done", 32'(bus.done), 32'd0);
        apply_stimulus(1'b1, 5'd3, 32'hF);
        check_output("match_done", 32'(bus.done), 32'd1);
        check_output("match_pass", 32'(bus.pass), 32'd1);
        check_output("match_err", 32'(bus.error_count), 32'd0);
        check_output("match_busy", 32'(bus.busy), 32'd0);

        // Extra writes after DONE
        apply_stimulus(1'b1, 5'd4, 32'h1234);
        check_output("extra_err", 32'(bus.error_count), 32'd1);
        check_output("extra_pass", 32'(bus.pass), 32'd0);
        check_output("extra_done", 32'(bus.done), 32'd1);
        for (int i = 0; i < 300; i++) apply_stimulus(1'b1, 5'd4, 32'h1234);
        check_output("extra_sat", 32'(bus.error_count), 32'd255);

        // Restart from DONE with a single mismatch on entry 1
        pulse_start();
        check_output("restart_err", 32'(bus.error_count), 32'd0);
        check_output("restart_done", 32'(bus.done), 32'd0);
        apply_stimulus(1'b1, 5'd1, 32'h5);
        apply_stimulus(1'b1, 5'd2, 32'hB);
        check_output("mis_err_mid", 32'(bus.error_count), 32'd1);
        apply_stimulus(1'b1, 5'd3, 32'hF);
        check_output("mis_done", 32'(bus.done), 32'd1);
        check_output("mis_pass", 32'(bus.pass), 32'd0);
        check_output("mis_err", 32'(bus.error_count), 32'd1);
        check_output("mis_fail_idx", 32'(bus.fail_idx), 32'd1);
        check_output("mis_fail_data", bus.fail_data, 32'hB);
        check_output("mis_timeout", 32'(bus.timeout), 32'd0);

        // Timeout exactly 8 cycles after start
        pulse_start();
        repeat (7) tick();
        check_output("to_not_yet", 32'(bus.done), 32'd0);
        check_output("to_busy", 32'(bus.busy), 32'd1);
        tick();
        check_output("to_done", 32'(bus.done), 32'd1);
        check_output("to_flag", 32'(bus.timeout), 32'd1);
        check_output("to_pass", 32'(bus.pass), 32'd0);

        // load_en and start are ignored during RUN
        pulse_start();
        apply_stimulus(1'b1, 5'd1, 32'h5);
        bus.start = 1'b1;
        bus.load_en = 1'b1; bus.load_idx = 6'd1; bus.load_reg = 5'd2; bus.load_data = 32'h77;
        tick();
        bus.start = 1'b0;
        bus.load_en = 1'b0;
        check_output("ign_start_idx", 32'(bus.check_idx), 32'd1);
        apply_stimulus(1'b1, 5'd2, 32'hA);
        apply_stimulus(1'b1, 5'd3, 32'hF);
        check_output("ign_load_pass", 32'(bus.pass), 32'd1);
        check_output("ign_load_err", 32'(bus.error_count), 32'd0);

        // Reset mid-run after a mismatch
        pulse_start();
        apply_stimulus(1'b1, 5'd1, 32'h5);
        apply_stimulus(1'b1, 5'd2, 32'hC);
        check_output("pre_rst_idx", 32'(bus.check_idx), 32'd2);
        check_output("pre_rst_fail_data", bus.fail_data, 32'hC);
        reset = 1'b0;
        tick();
        check_all_zero("mid_reset");
        reset = 1'b1;

        // Out-of-range load must not alias onto entry 0
        load_entry(6'd4, 5'd1, 32'h99);

        // A write in the start cycle is not checked
        bus.start = 1'b1;
        bus.ctrl_writeEnable = 1'b1; bus.ctrl_writeReg = 5'd5; bus.data_writeReg = 32'h1;
        tick();
        bus.start = 1'b0;
        bus.ctrl_writeEnable = 1'b0; bus.ctrl_writeReg = '0; bus.data_writeReg = '0;
        check_output("start_write_idx", 32'(bus.check_idx), 32'd0);
        check_output("start_write_err", 32'(bus.error_count), 32'd0);
        apply_stimulus(1'b1, 5'd1, 32'h5);
        apply_stimulus(1'b1, 5'd2, 32'hA);
        apply_stimulus(1'b1, 5'd3, 32'hF);
        check_output("post_rst_done", 32'(bus.done), 32'd1);
        check_output("post_rst_pass", 32'(bus.pass), 32'd1);
        check_output("post_rst_err", 32'(bus.error_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regwrite_checker.md
# regwrite_checker

Synthesizable on-chip checker: the consuming end of the processor's register-file write port. It snoops every write the `skeleton` processor commits (`ctrl_writeEnable`, `ctrl_writeReg`, `data_writeReg`) and compares each one, in order, against a preloaded table of expected writes. It reports pass/fail, an error count and the first mismatch. This replaces manual inspection of stepped simulations with a self-checking verdict usable both in the bench and on the board.

## Interface
Parameters:
- `NUM_EXPECT`, 16: number of expected writes in the table (1..64).
- `TIMEOUT`, 255: idle cycles without a checked write before the run aborts.

Ports:
- `clock`  in  1: single clock. All state changes on the rising edge.
- `reset`  in  1: **synchronous, active-low**. While low at a rising edge, all state is cleared.
- `load_en`  in  1: writes one table entry. Accepted only in IDLE.
- `load_idx`  in  6: table index, `0..NUM_EXPECT-1`. Out-of-range indices are ignored.
- `load_reg`  in  5: expected destination register.
- `load_data`  in  32: expected write data.
- `start`  in  1: one-cycle pulse that begins a checking run.
- `ctrl_writeEnable`  in  1: snooped regfile write enable.
- `ctrl_writeReg`  in  5: snooped destination register.
- `data_writeReg`  in  32: snooped write data.
- `busy`  out  1: high in RUN.
- `done`  out  1: high in DONE.
- `pass`  out  1: valid when `done` is high.
- `timeout`  out  1: set when the run ended by timeout.
- `error_count`  out  8: number of mismatches plus extra writes; saturates at 255.
- `check_idx`  out  6: index of the next expected entry.
- `fail_idx`  out  6: index of the first mismatch.
- `fail_data`  out  32: data observed at the first mismatch.

## Operation
- States: IDLE, RUN, DONE.
- Reset: state = IDLE. Every output is 0. The table contents are not cleared.
- IDLE:
  - `load_en` writes `{load_reg, load_data}` into entry `load_idx`.
  - `start` moves to RUN. `check_idx`, `error_count`, `timeout`, `fail_*`, the first-fail flag and the idle counter are all cleared.
  - A snooped write in the same cycle as `start` is not checked.
- RUN, on a snooped write (`ctrl_writeEnable`=1 and `ctrl_writeReg`≠0):
  - The write is compared with entry `check_idx` on both register and data.
  - On mismatch: `error_count`+1. If this is the first failure, latch `fail_idx`=`check_idx` and `fail_data`=`data_writeReg`.
  - In all cases: `check_idx`+1 and the idle counter resets.
  - When the incremented index equals `NUM_EXPECT`, go to DONE with `pass` = (final `error_count` == 0).
- Writes to `$r0` are never checked; the regfile discards them.
- RUN with no checked write: the idle counter increments. When it reaches `TIMEOUT`, go to DONE with `timeout`=1 and `pass`=0.
- DONE:
  - Any further checked write is an extra write: `error_count`+1 (saturating) and `pass` is cleared.
  - `start` restarts the run exactly as from IDLE.
  - The table is reloadable only after `reset` returns the block to IDLE.
- Ignored inputs: `load_en` in RUN or DONE; `start` in RUN.
- `reset` low mid-run aborts immediately to IDLE with no verdict.

## Timing
- Snooped inputs are sampled on the rising edge of `clock`. The integrator feeds them from the same domain as `regfile_clock` writes.
- All outputs are registered. `error_count`, `check_idx` and `fail_*` update 1 cycle after the sampled write.
- `done` and `pass` are valid 1 cycle after the final expected write is sampled, and hold until `start` or reset.
- Back-to-back writes on consecutive cycles are all checked; there is no stall and no backpressure.
- Timeout: DONE is entered exactly `TIMEOUT` cycles after the last checked write, or after `start` if no write follows.
- Table read is combinational from `check_idx`; a write can be checked in the first RUN cycle.

## Structure
- Shared package `checker_pkg`: state encodings (IDLE=0, RUN=1, DONE=2), `IDX_W`=6, `REG_W`=5, `DATA_W`=32, `ERR_W`=8.
- One sub-module, `expect_table`: `NUM_EXPECT`×37-bit register array. Synchronous write port, asynchronous read port.
- The top level holds the FSM, counters, comparator and first-fail latch.

## Test plan
- **All match:** load 3 entries `{1,0x5}`, `{2,0xA}`, `{3,0xF}` with `NUM_EXPECT`=3; start; drive matching writes on consecutive cycles → `done`=1 and `pass`=1 one cycle after the third write; `error_count`=0.
- **Single mismatch:** same table; second write drives `$2`=0xB → `pass`=0, `error_count`=1, `fail_idx`=1, `fail_data`=0xB.
- **$r0 filter and timeout:** writes to `$0` interleaved with correct writes are ignored. With `TIMEOUT`=8 and no write after `start` → `done`=1 exactly 8 cycles later, `timeout`=1, `pass`=0.
- **Extra write:** after a passing DONE, one more write to `$4` → `error_count`=1, `pass`=0. 300 extra writes → `error_count` saturates at 255.
- **Reset mid-run:** `reset` low at `check_idx`=2 → next cycle all outputs 0, state IDLE. The table is preserved; a second `start` passes.
- **Ignored controls:** `load_en` during RUN leaves the table unchanged; `start` during RUN leaves `check_idx` unchanged.
